// File: rtl/spi_input_receiver_dac_if.sv
// rtl/spi_input_receiver_dac_if.sv - SPI DAC-frame bus (SCLK, SYNC_n, DIN)
//
// master : drives the serial bus (SPI transmitter or bench model)
// slave  : receives the serial bus (spi_input_receiver_dac)
interface spi_input_receiver_dac_if;
    logic input_SPI_SCLK;
    logic input_SPI_SYNC_n;
    logic input_SPI_DIN;

    modport master (
        output input_SPI_SCLK,
        output input_SPI_SYNC_n,
        output input_SPI_DIN
    );

    modport slave (
        input input_SPI_SCLK,
        input input_SPI_SYNC_n,
        input input_SPI_DIN
    );
endinterface

// File: rtl/spi_input_receiver_dac.sv
// rtl/spi_input_receiver_dac.sv - oversampling SPI responder decoding 16-bit DAC frames
//
// Frame format: X X M1 M0 D11..D0, MSB first, framed by active-low SYNC_n.
// Ports:
//   clock_50Mhz   system clock
//   reset         synchronous, active-high reset
//   spi           SPI bus (slave modport): SCLK, SYNC_n, DIN, all asynchronous
//   outputSample  D11..D0 of the last complete frame
//   outputMode    bits 13:12 of the last complete frame
//   sampleValid   one-cycle pulse when outputSample/outputMode update
//   modeError     one-cycle pulse with sampleValid when mode != 0
//   frameAborted  one-cycle pulse when SYNC_n rises after 1..15 bits
//   isBusy        high while a frame is in progress
//   frameCount / errorCount  (only with SPI_RX_FRAME_COUNT_EN defined)
//                 completed frames; mode errors plus aborts (wrapping)
module spi_input_receiver_dac #(
    parameter bit SAMPLE_ON_RISING = 1'b1,
    parameter int SYNC_STAGES      = 2,
    parameter int FRAME_BITS       = 16
) (
    input  logic                          clock_50Mhz,
    input  logic                          reset,
    spi_input_receiver_dac_if.slave       spi,
    output logic [11:0]                   outputSample,
    output logic [1:0]                    outputMode,
    output logic                          sampleValid,
    output logic                          modeError,
    output logic                          frameAborted,
    output logic                          isBusy
`ifdef SPI_RX_FRAME_COUNT_EN
    ,
    output logic [15:0]                   frameCount,
    output logic [15:0]                   errorCount
`endif
);

    generate
        if (FRAME_BITS != 16) begin : g_bad_frame_bits
            $error("spi_input_receiver_dac: FRAME_BITS must be 16");
        end
        if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync_stages
            $error("spi_input_receiver_dac: SYNC_STAGES must be 2..3");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH, WAIT_HIGH} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] sync_n_sync;
    logic [SYNC_STAGES-1:0] din_sync;
    logic                   sclk_prev;
    logic                   sync_n_prev;

    logic                   sclk_s;
    logic                   sync_n_s;
    logic                   din_s;
    logic                   sample_edge;
    logic                   sync_fall;
    logic                   sync_rise;

    state_t                 state;
    logic [FRAME_BITS-1:0]  shift_reg;
    logic [4:0]             bit_count;

    // Synchronizers and edge-history registers are deliberately not reset:
    // they keep tracking the pins during reset, so a SYNC_n that is already
    // low when reset releases does not look like a fresh falling edge.
    always_ff @(posedge clock_50Mhz) begin
        sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0],   spi.input_SPI_SCLK};
        sync_n_sync <= {sync_n_sync[SYNC_STAGES-2:0], spi.input_SPI_SYNC_n};
        din_sync    <= {din_sync[SYNC_STAGES-2:0],    spi.input_SPI_DIN};
        sclk_prev   <= sclk_s;
        sync_n_prev <= sync_n_s;
    end

    assign sclk_s   = sclk_sync[SYNC_STAGES-1];
    assign sync_n_s = sync_n_sync[SYNC_STAGES-1];
    assign din_s    = din_sync[SYNC_STAGES-1];

    assign sample_edge = SAMPLE_ON_RISING ? (sclk_s & ~sclk_prev) : (~sclk_s & sclk_prev);
    assign sync_fall   = sync_n_prev & ~sync_n_s;
    assign sync_rise   = ~sync_n_prev & sync_n_s;

    always_ff @(posedge clock_50Mhz) begin
        if (reset) begin
            state        <= IDLE;
            shift_reg    <= '0;
            bit_count    <= '0;
            outputSample <= '0;
            outputMode   <= '0;
            sampleValid  <= 1'b0;
            modeError    <= 1'b0;
            frameAborted <= 1'b0;
            isBusy       <= 1'b0;
        end else begin
            sampleValid  <= 1'b0;
            modeError    <= 1'b0;
            frameAborted <= 1'b0;
            case (state)
                IDLE: begin
                    if (sync_fall) begin
                        bit_count <= '0;
                        state     <= SHIFT;
                        isBusy    <= 1'b1;
                    end
                end
                SHIFT: begin
                    // SYNC_n release wins over a coincident SCLK edge.
                    if (sync_rise) begin
                        frameAborted <= (bit_count != 5'd0);
                        state        <= IDLE;
                        isBusy       <= 1'b0;
                    end else if (sample_edge) begin
                        shift_reg <= {shift_reg[FRAME_BITS-2:0], din_s};
                        bit_count <= bit_count + 5'd1;
                        if (bit_count == 5'(FRAME_BITS - 1)) begin
                            state <= LATCH;
                        end
                    end
                end
                LATCH: begin
                    outputSample <= shift_reg[11:0];
                    outputMode   <= shift_reg[13:12];
                    sampleValid  <= 1'b1;
                    modeError    <= (shift_reg[13:12] != 2'b00);
                    // A SYNC_n release landing in this cycle must not be lost,
                    // otherwise the FSM would sit in WAIT_HIGH for a whole frame.
                    if (sync_rise) begin
                        state  <= IDLE;
                        isBusy <= 1'b0;
                    end else begin
                        state <= WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    if (sync_rise) begin
                        state  <= IDLE;
                        isBusy <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    isBusy <= 1'b0;
                end
            endcase
        end
    end

`ifdef SPI_RX_FRAME_COUNT_EN
    always_ff @(posedge clock_50Mhz) begin
        if (reset) begin
            frameCount <= '0;
            errorCount <= '0;
        end else begin
            if (sampleValid) begin
                frameCount <= frameCount + 16'd1;
            end
            if (modeError || frameAborted) begin
                errorCount <= errorCount + 16'd1;
            end
        end
    end
`endif

endmodule
